// File: rtl/video_win_pkg.sv
// Shared types and helpers for the window generator's line-buffer ring.
package video_win_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        READ = 2'd2
    } rd_state_t;

    // Increment a ring index, wrapping to zero after n-1.
    function automatic int unsigned ring_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/line_buf_rd_ctrl_ring_ptr.sv
// Wrapping ring index with a one-hot decode of the current position.
module ring_ptr
    import video_win_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         adv_i,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] onehot_o
);

    logic [W-1:0] idx_q;
    logic [W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (adv_i) begin
            idx_d = W'(ring_inc(32'(idx_q), N));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o    = idx_q;
    assign onehot_o = {{(N-1){1'b0}}, 1'b1} << idx_q;

endmodule

// File: rtl/line_buf_rd_ctrl.sv
// Read-side scheduler for the line_buf ring: steers writes and pops
// WIN_ROWS aligned rows once a full window of the current frame is held.
//
//  state | meaning
//  IDLE  | waiting for a full window with a fresh newest line
//  POP   | one-cycle pop of every buffer except the write target
//  READ  | window rows streaming; wait for the oldest row's line end
module line_buf_rd_ctrl
    import video_win_pkg::*;
#(
    parameter  int WIN_ROWS = 3,
    localparam int NUM_BUF  = WIN_ROWS + 1,
    localparam int IDX_W    = $clog2(NUM_BUF)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_push_i,
    input  logic               in_line_start_i,
    input  logic               in_line_end_i,
    input  logic               in_frame_start_i,
    input  logic [NUM_BUF-1:0] buf_empty_i,
    input  logic [NUM_BUF-1:0] buf_unread_i,
    input  logic [NUM_BUF-1:0] buf_line_end_i,
    output logic [NUM_BUF-1:0] wr_sel_o,
    output logic [NUM_BUF-1:0] pop_line_o,
    output logic [IDX_W-1:0]   oldest_idx_o,
    output logic               rd_busy_o,
    output logic               ovf_o
);

    localparam int CNT_W = $clog2(WIN_ROWS + 1);

    rd_state_t        state_q, state_d;
    logic [CNT_W-1:0] rows_cnt_q, rows_cnt_d;
    logic [IDX_W-1:0] oldest_q, oldest_d;
    logic [IDX_W-1:0] rd_excl_q, rd_excl_d;
    logic             ovf_q, ovf_d;

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] wr_idx_next;
    logic [IDX_W-1:0] newest_idx;
    logic [IDX_W-1:0] excl_idx;
    logic             line_end_beat;
    logic             frame_start_beat;
    logic             window_full;

    assign line_end_beat    = in_push_i & in_line_end_i;
    assign frame_start_beat = in_push_i & in_line_start_i & in_frame_start_i;

    ring_ptr #(
        .N (NUM_BUF),
        .W (IDX_W)
    ) u_wr_ptr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .adv_i    (line_end_beat),
        .idx_o    (wr_idx),
        .onehot_o (wr_sel_o)
    );

    assign wr_idx_next = IDX_W'(ring_inc(32'(wr_idx), NUM_BUF));
    assign newest_idx  = (wr_idx == '0) ? IDX_W'(NUM_BUF - 1) : wr_idx - 1'b1;

    // The write target is allowed to be empty; every other buffer must hold a line.
    assign window_full = (rows_cnt_q == CNT_W'(WIN_ROWS)) &&
                         buf_unread_i[newest_idx] &&
                         (&(~buf_empty_i | wr_sel_o));

    always_comb begin
        rows_cnt_d = rows_cnt_q;
        if (frame_start_beat) begin
            rows_cnt_d = line_end_beat ? CNT_W'(1) : '0;
        end else if (line_end_beat && (rows_cnt_q != CNT_W'(WIN_ROWS))) begin
            rows_cnt_d = rows_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pop_line_o = '0;
        oldest_d   = oldest_q;
        rd_excl_d  = rd_excl_q;
        case (state_q)
            IDLE: begin
                if (window_full) begin
                    state_d = POP;
                end
            end
            POP: begin
                pop_line_o = ~wr_sel_o;
                rd_excl_d  = wr_idx;
                oldest_d   = wr_idx_next;
                state_d    = READ;
            end
            READ: begin
                if (buf_line_end_i[oldest_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every buffer other than the excluded one is being read, so any
    // advance that does not land back on it collides with the window.
    assign excl_idx = (state_q == POP) ? wr_idx : rd_excl_q;
    assign ovf_d    = line_end_beat && (state_q != IDLE) && (wr_idx_next != excl_idx);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rows_cnt_q <= '0;
            oldest_q   <= '0;
            rd_excl_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_cnt_q <= rows_cnt_d;
            oldest_q   <= oldest_d;
            rd_excl_q  <= rd_excl_d;
            ovf_q      <= ovf_d;
        end
    end

    assign oldest_idx_o = oldest_q;
    assign rd_busy_o    = (state_q != IDLE);
    assign ovf_o        = ovf_q;

endmodule
